// File: rtl/sram_fill_ctrl.sv
// Write-side initiator for the fetch-stage SRAM: fills one BEATS-long line from a
// valid/ready beat stream, or sweeps the whole array to zero.
module sram_fill_ctrl #(
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEATS      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear_req,
  input  logic                            fill_req,
  input  logic [$clog2(SIZE/BEATS)-1:0]   fill_line,
  input  logic                            beat_valid,
  input  logic [DATA_WIDTH-1:0]           beat_data,
  output logic                            beat_ready,
  output logic                            busy,
  output logic                            fill_done,
  output logic                            clear_done,
  output logic                            sram_wr_en,
  output logic [$clog2(SIZE)-1:0]         sram_wr_addr,
  output logic [DATA_WIDTH-1:0]           sram_wr_data
);

  localparam int unsigned ADDR_W = $clog2(SIZE);
  localparam int unsigned LINE_W = $clog2(SIZE / BEATS);
  localparam int unsigned BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FILL,
    DONE
  } state_t;

  state_t              state;
  logic [LINE_W-1:0]   line;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]   clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line       <= '0;
      beat_cnt   <= '0;
      clr_cnt    <= '0;
      busy       <= 1'b0;
      beat_ready <= 1'b0;
      fill_done  <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fill_done  <= 1'b0;
          clear_done <= 1'b0;
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else if (fill_req) begin
            state      <= FILL;
            line       <= fill_line;
            beat_cnt   <= '0;
            busy       <= 1'b1;
            beat_ready <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(SIZE - 1)) begin
            state      <= DONE;
            clear_done <= 1'b1;
          end
        end
        FILL: begin
          if (beat_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              state      <= DONE;
              beat_ready <= 1'b0;
              fill_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          fill_done  <= 1'b0;
          clear_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write port is combinational so a beat commits on the same edge it is accepted.
  always_comb begin
    sram_wr_en   = 1'b0;
    sram_wr_addr = '0;
    sram_wr_data = '0;
    case (state)
      CLEAR: begin
        sram_wr_en   = 1'b1;
        sram_wr_addr = clr_cnt;
      end
      FILL: begin
        if (beat_valid) begin
          sram_wr_en   = 1'b1;
          sram_wr_addr = {line, beat_cnt};
          sram_wr_data = beat_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_fill_ctrl.sv
// Directed bench for sram_fill_ctrl (SIZE=16, BEATS=4): fill, gapped fill, clear,
// request collision and mid-fill reset.
module tb_sram_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic        fill_req;
  logic [1:0]  fill_line;
  logic        beat_valid;
  logic [31:0] beat_data;
  logic        beat_ready;
  logic        busy;
  logic        fill_done;
  logic        clear_done;
  logic        sram_wr_en;
  logic [3:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  sram_fill_ctrl #(
    .SIZE       (16),
    .DATA_WIDTH (32),
    .BEATS      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req    (clear_req),
    .fill_req     (fill_req),
    .fill_line    (fill_line),
    .beat_valid   (beat_valid),
    .beat_data    (beat_data),
    .beat_ready   (beat_ready),
    .busy         (busy),
    .fill_done    (fill_done),
    .clear_done   (clear_done),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [6:0] pat;
    int         exp_addr;

    rst_n = 1'b0; clear_req = 1'b0; fill_req = 1'b0; fill_line = '0;
    beat_valid = 1'b0; beat_data = '0;
    #2;
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_beat_ready", 64'(beat_ready), 64'd0);
    chk("rst_wr_en",      64'(sram_wr_en), 64'd0);
    chk("rst_fill_done",  64'(fill_done),  64'd0);
    chk("rst_clear_done", 64'(clear_done), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back fill of line 3
    @(negedge clk); fill_req = 1'b1; fill_line = 2'd3; #1;
    chk("f1_idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fill_req = 1'b0; beat_valid = 1'b1; beat_data = 32'hA0 + 32'(i); #1;
      chk("f1_wr_en", 64'(sram_wr_en),   64'd1);
      chk("f1_addr",  64'(sram_wr_addr), 64'(12 + i));
      chk("f1_data",  64'(sram_wr_data), 64'(32'hA0 + 32'(i)));
      chk("f1_ready", 64'(beat_ready),   64'd1);
      chk("f1_busy",  64'(busy),         64'd1);
    end
    @(negedge clk); beat_valid = 1'b0; #1;
    chk("f1_done",       64'(fill_done),  64'd1);
    chk("f1_done_busy",  64'(busy),       64'd1);
    chk("f1_done_ready", 64'(beat_ready), 64'd0);
    chk("f1_done_wr_en", 64'(sram_wr_en), 64'd0);
    chk("f1_done_clr",   64'(clear_done), 64'd0);
    @(negedge clk); #1;
    chk("f1_idle_busy2", 64'(busy),      64'd0);
    chk("f1_done_drop",  64'(fill_done), 64'd0);

    // Gapped fill of line 1, valid pattern 1,0,0,1,1,0,1
    pat = 7'b1011001;
    exp_addr = 4;
    @(negedge clk); fill_req = 1'b1; fill_line = 2'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); fill_req = 1'b0; beat_valid = pat[i]; beat_data = 32'hB0 + 32'(i); #1;
      chk("f2_wr_en", 64'(sram_wr_en), 64'(pat[i]));
      if (pat[i]) begin
        chk("f2_addr", 64'(sram_wr_addr), 64'(exp_addr));
        chk("f2_data", 64'(sram_wr_data), 64'(32'hB0 + 32'(i)));
        exp_addr++;
      end else begin
        chk("f2_addr_idle", 64'(sram_wr_addr), 64'd0);
        chk("f2_data_idle", 64'(sram_wr_data), 64'd0);
        chk("f2_no_done",   64'(fill_done),    64'd0);
      end
    end
    @(negedge clk); beat_valid = 1'b0; #1;
    chk("f2_done", 64'(fill_done), 64'd1);
    @(negedge clk); #1;
    chk("f2_idle_busy", 64'(busy), 64'd0);

    // Clear sweep with an ignored fill_req mid-sweep
    @(negedge clk); clear_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); clear_req = 1'b0; fill_req = (i == 3); fill_line = 2'd0; #1;
      chk("c1_wr_en",  64'(sram_wr_en),   64'd1);
      chk("c1_addr",   64'(sram_wr_addr), 64'(i));
      chk("c1_data",   64'(sram_wr_data), 64'd0);
      chk("c1_cdone",  64'(clear_done),   64'd0);
      chk("c1_ready",  64'(beat_ready),   64'd0);
    end
    @(negedge clk); fill_req = 1'b0; #1;
    chk("c1_done",       64'(clear_done), 64'd1);
    chk("c1_no_fdone",   64'(fill_done),  64'd0);
    chk("c1_done_wr_en", 64'(sram_wr_en), 64'd0);
    @(negedge clk); #1;
    chk("c1_idle_busy",  64'(busy),       64'd0);
    chk("c1_done_once",  64'(clear_done), 64'd0);
    @(negedge clk); #1;
    chk("c1_no_queue",   64'(busy),       64'd0);

    // clear_req and fill_req together: clear wins, fill dropped
    @(negedge clk); clear_req = 1'b1; fill_req = 1'b1; fill_line = 2'd2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); clear_req = 1'b0; fill_req = 1'b0; beat_valid = 1'b1; beat_data = 32'hDEAD; #1;
      chk("c2_wr_en", 64'(sram_wr_en),   64'd1);
      chk("c2_addr",  64'(sram_wr_addr), 64'(i));
      chk("c2_data",  64'(sram_wr_data), 64'd0);
    end
    @(negedge clk); beat_valid = 1'b0; #1;
    chk("c2_cdone",    64'(clear_done), 64'd1);
    chk("c2_no_fdone", 64'(fill_done),  64'd0);
    @(negedge clk); #1;
    chk("c2_idle_busy", 64'(busy), 64'd0);

    // Reset during a line-2 fill, then refill from beat 0
    @(negedge clk); fill_req = 1'b1; fill_line = 2'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); fill_req = 1'b0; beat_valid = 1'b1; beat_data = 32'hC0 + 32'(i); #1;
      chk("r_addr", 64'(sram_wr_addr), 64'(8 + i));
    end
    @(negedge clk); beat_data = 32'hC2; #1;
    chk("r_pre_wr_en", 64'(sram_wr_en),   64'd1);
    chk("r_pre_addr",  64'(sram_wr_addr), 64'd10);
    rst_n = 1'b0; #1;
    chk("r_wr_en", 64'(sram_wr_en),   64'd0);
    chk("r_addr0", 64'(sram_wr_addr), 64'd0);
    chk("r_busy",  64'(busy),         64'd0);
    chk("r_ready", 64'(beat_ready),   64'd0);
    @(negedge clk); rst_n = 1'b1; beat_valid = 1'b0;
    @(negedge clk); fill_req = 1'b1; fill_line = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); fill_req = 1'b0; beat_valid = 1'b1; beat_data = 32'hD0 + 32'(i); #1;
      chk("r2_wr_en", 64'(sram_wr_en),   64'd1);
      chk("r2_addr",  64'(sram_wr_addr), 64'(8 + i));
      chk("r2_data",  64'(sram_wr_data), 64'(32'hD0 + 32'(i)));
    end
    @(negedge clk); beat_valid = 1'b0; #1;
    chk("r2_done", 64'(fill_done), 64'd1);
    @(negedge clk); #1;
    chk("r2_idle_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
